riscv_hwloop_jump_ctrl: RTL and testbench
=========================================

Name: riscv_hwloop_jump_ctrl

Overview:
- Consumer of the hardware-loop register file. Reads the per-loop start address, end address and counter arrays.
- Watches the PC of each instruction as it retires from ID, and detects loop-end hits.
- On a hit, issues exactly one counter-decrement strobe back to the register file.
- When another iteration remains, raises a registered jump request toward the prefetcher. The request is held until fetch accepts it or the pipeline flushes it.

Parameters:
- N_REGS, 2, number of hardware-loop register sets. Index 0 is the innermost loop and has the highest priority.
- N_REG_BITS, $clog2(N_REGS), width of the loop index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- current_pc_i  in  32  PC of the instruction in ID.
- pc_valid_i  in  1  instruction at current_pc_i retires from ID this cycle. It is high for one cycle per instruction.
- hwlp_start_addr_i  in  N_REGS x 32  loop start addresses.
- hwlp_end_addr_i  in  N_REGS x 32  loop end addresses, meaning the address of the last instruction in the loop body.
- hwlp_counter_i  in  N_REGS x 32  remaining iteration counts.
- hwlp_jump_ready_i  in  1  fetch accepts the jump request this cycle.
- flush_i  in  1  pipeline flush (exception, branch or debug). Drops any pending request.
- hwlp_dec_cnt_o  out  N_REGS  decrement strobe. At most one bit is set per cycle.
- hwlp_jump_o  out  1  jump request to fetch.
- hwlp_target_o  out  32  jump target, valid while hwlp_jump_o is high.
- hwlp_loop_id_o  out  N_REG_BITS  index of the loop that owns the pending jump.
- busy_o  out  1  a jump request is pending. Equals hwlp_jump_o.

Behaviour:
- Match vector, combinational: hit[k] = (current_pc_i == hwlp_end_addr_i[k]) && (hwlp_counter_i[k] != 0).
- Selection: sel = lowest k with hit[k] set, i.e. fixed priority with index 0 first. any_hit = OR of the hit vector.
- Counter comparisons are unsigned 32-bit. A counter of 0 means the loop is inactive, and its end address is ignored.
- FSM states are IDLE and REQ. The reset state is IDLE.
- IDLE, when pc_valid_i && any_hit:
  - hwlp_dec_cnt_o[sel] = 1 in the same cycle (combinational). The register file applies the decrement at the next edge.
  - If hwlp_counter_i[sel] >= 2: go to REQ, latch target <= hwlp_start_addr_i[sel], latch loop_id <= sel.
  - If hwlp_counter_i[sel] == 1: last iteration. Decrement only, stay in IDLE, no jump; execution falls through.
- IDLE otherwise: hwlp_dec_cnt_o = 0.
- REQ:
  - hwlp_jump_o = 1. Target and loop id are held stable.
  - hwlp_dec_cnt_o is forced to 0, and matches are ignored.
  - hwlp_jump_ready_i = 1 -> IDLE at the next edge. Latency from the triggering retire to first hwlp_jump_o is 1 cycle.
  - flush_i = 1 -> IDLE at the next edge, no jump issued. flush_i takes priority over hwlp_jump_ready_i in the same cycle.
  - The decrement already issued is not undone on flush.
- flush_i in IDLE suppresses hwlp_dec_cnt_o and any REQ transition in that cycle.
- Nested loops sharing one end address: only the selected (inner) loop is decremented, and the outer loop does not jump that cycle. Software must give nested loops distinct end addresses. This is a documented restriction, not an error condition.
- Register writes landing in the same cycle as a hit do not affect selection; selection uses the current register outputs.
- Reset values: hwlp_jump_o=0, busy_o=0, hwlp_target_o=32'h0, hwlp_loop_id_o=0, hwlp_dec_cnt_o=0. Reset mid-REQ drops the request immediately (asynchronous).
- Assertions:
  - $countones(hwlp_dec_cnt_o) <= 1.
  - hwlp_target_o and hwlp_loop_id_o are stable while hwlp_jump_o is high.
  - No hwlp_dec_cnt_o while in REQ.

Test Plan:
- Basic loop. Setup: loop0 start=0x100, end=0x10C, cnt=3, ready held 1. Stimulus: retire 0x10C three times. Required response:
  - Hits 1 and 2: dec[0] pulses, jump to 0x100 one cycle later.
  - Hit 3 (cnt=1): dec[0] pulses, no jump.
  - Afterwards cnt=0, and a further retire of 0x10C gives no dec and no jump.
- Backpressure. Setup: loop0 cnt=5. Stimulus: hit, ready held 0 for 4 cycles. Required response:
  - jump_o and target=0x100 are held 4 cycles.
  - A further retire of 0x10C during REQ produces no dec.
  - ready=1 returns the FSM to IDLE next cycle.
- Flush. Stimulus: hit with cnt=4, then flush_i=1 and ready=1 in the same REQ cycle. Required response: FSM returns to IDLE, no jump accepted, counter is 3.
- Priority. Setup: loop0 end=0x200 cnt=2, loop1 end=0x200 cnt=7. Stimulus: retire 0x200. Required response:
  - Only dec[0] pulses; target=loop0 start; loop_id=0.
  - Next hit (cnt0=1): dec[0] only, no jump; loop1 count stays 7.
- Inactive and non-valid cases:
  - Counter 0 with matching PC: no response.
  - Matching PC with pc_valid_i=0: no response.
- Reset. Stimulus: assert rst_n=0 while in REQ. Required response: jump_o, target and dec all 0 asynchronously; after release the FSM is in IDLE.

Source files
------------

// File: rtl/riscv_hwloop_jump_ctrl.sv
// Hardware-loop end detection: decrements the selected loop counter on an end-address hit
// and holds a registered jump request back to the loop start until fetch takes it or a flush drops it.
module riscv_hwloop_jump_ctrl #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                current_pc_i,
  input  logic                       pc_valid_i,
  input  logic [N_REGS-1:0][31:0]    hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0]    hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]    hwlp_counter_i,
  input  logic                       hwlp_jump_ready_i,
  input  logic                       flush_i,
  output logic [N_REGS-1:0]          hwlp_dec_cnt_o,
  output logic                       hwlp_jump_o,
  output logic [31:0]                hwlp_target_o,
  output logic [N_REG_BITS-1:0]      hwlp_loop_id_o,
  output logic                       busy_o
);

  typedef enum logic {IDLE, REQ} state_e;

  state_e                state_q, state_d;
  logic [31:0]           target_q, target_d;
  logic [N_REG_BITS-1:0] loop_id_q, loop_id_d;
  logic [N_REGS-1:0]     hit;
  logic [N_REGS-1:0]     dec_cnt;
  logic [N_REG_BITS-1:0] sel;
  logic                  any_hit;
  logic                  trigger;
  logic                  last_iter;

  // A zero counter marks the loop inactive, so its end address never matches.
  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_hit
      assign hit[gi] = (current_pc_i == hwlp_end_addr_i[gi]) && (hwlp_counter_i[gi] != 32'd0);
    end
  endgenerate

  // Walk from the outermost loop down so the innermost hit wins.
  always_comb begin
    sel = '0;
    for (int k = N_REGS - 1; k >= 0; k--) begin
      if (hit[k]) sel = N_REG_BITS'(k);
    end
  end

  assign any_hit   = |hit;
  assign trigger   = (state_q == IDLE) && pc_valid_i && any_hit && !flush_i;
  assign last_iter = (hwlp_counter_i[sel] == 32'd1);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    loop_id_d = loop_id_q;
    dec_cnt   = '0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          dec_cnt[sel] = 1'b1;
          if (!last_iter) begin
            state_d   = REQ;
            target_d  = hwlp_start_addr_i[sel];
            loop_id_d = sel;
          end
        end
      end
      REQ: begin
        if (flush_i || hwlp_jump_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      target_q  <= 32'h0;
      loop_id_q <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      loop_id_q <= loop_id_d;
    end
  end

  // The strobe is combinational, so it is masked directly while reset is held.
  assign hwlp_dec_cnt_o = rst_n ? dec_cnt : '0;
  assign hwlp_jump_o    = (state_q == REQ);
  assign busy_o         = (state_q == REQ);
  assign hwlp_target_o  = target_q;
  assign hwlp_loop_id_o = loop_id_q;

  a_dec_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(hwlp_dec_cnt_o));
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (hwlp_jump_o ##1 hwlp_jump_o) |-> ($stable(hwlp_target_o) && $stable(hwlp_loop_id_o)));
  a_no_dec_in_req: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == REQ) |-> (hwlp_dec_cnt_o == '0));

endmodule

// File: tb/tb_riscv_hwloop_jump_ctrl.sv
// Self-checking bench: the bench owns the loop register file and a behavioural model of the
// loop controller; directed test-plan scenarios are followed by randomized traffic.
module tb_riscv_hwloop_jump_ctrl;

  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       current_pc;
  logic              pc_valid;
  logic [NR-1:0][31:0] start_p, end_p, cnt_p;
  logic              jump_ready;
  logic              flush;
  logic [NR-1:0]     dec_cnt;
  logic              jump;
  logic [31:0]       target;
  logic [0:0]        loop_id;
  logic              busy;

  // Loop register file and reference controller state.
  logic [31:0] m_start [NR];
  logic [31:0] m_end   [NR];
  logic [31:0] m_cnt   [NR];
  bit          m_pend;
  logic [31:0] m_tgt;
  int          m_id;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      start_p[i] = m_start[i];
      end_p[i]   = m_end[i];
      cnt_p[i]   = m_cnt[i];
    end
  end

  riscv_hwloop_jump_ctrl #(.N_REGS(NR)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .current_pc_i      (current_pc),
    .pc_valid_i        (pc_valid),
    .hwlp_start_addr_i (start_p),
    .hwlp_end_addr_i   (end_p),
    .hwlp_counter_i    (cnt_p),
    .hwlp_jump_ready_i (jump_ready),
    .flush_i           (flush),
    .hwlp_dec_cnt_o    (dec_cnt),
    .hwlp_jump_o       (jump),
    .hwlp_target_o     (target),
    .hwlp_loop_id_o    (loop_id),
    .busy_o            (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic set_loop(input int k, input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
    m_start[k] = s;
    m_end[k]   = e;
    m_cnt[k]   = c;
  endtask

  // One clock cycle: drive, check against the model, then commit the model after the edge.
  task automatic step(input logic [31:0] pc, input logic v, input logic rdy, input logic fl,
                      input bit show);
    int          hit_k;
    logic [NR-1:0] exp_dec;
    bit          n_pend;
    logic [31:0] n_tgt;
    int          n_id;
    @(negedge clk);
    current_pc = pc;
    pc_valid   = v;
    jump_ready = rdy;
    flush      = fl;
    #1;
    hit_k = -1;
    if (!m_pend && v && !fl) begin
      for (int k = 0; k < NR; k++)
        if (hit_k < 0 && pc == m_end[k] && m_cnt[k] != 0) hit_k = k;
    end
    exp_dec = '0;
    if (hit_k >= 0) exp_dec[hit_k] = 1'b1;
    check_val("dec", 32'(dec_cnt), 32'(exp_dec));
    check_val("jump", 32'(jump), 32'(m_pend));
    check_val("busy", 32'(busy), 32'(m_pend));
    if (m_pend) begin
      check_val("target", target, m_tgt);
      check_val("loop_id", 32'(loop_id), 32'(m_id));
    end
    if (show)
      $display("step pc=%h v=%0d rdy=%0d fl=%0d dec=%b jump=%0d tgt=%h id=%0d cnt0=%0d cnt1=%0d",
               pc, v, rdy, fl, dec_cnt, jump, target, loop_id, m_cnt[0], m_cnt[1]);
    n_pend = m_pend;
    n_tgt  = m_tgt;
    n_id   = m_id;
    if (m_pend) begin
      if (fl || rdy) n_pend = 1'b0;
    end else if (hit_k >= 0) begin
      if (m_cnt[hit_k] >= 2) begin
        n_pend = 1'b1;
        n_tgt  = m_start[hit_k];
        n_id   = hit_k;
      end
    end
    @(posedge clk);
    #1;
    if (hit_k >= 0) m_cnt[hit_k] = m_cnt[hit_k] - 1;
    m_pend = n_pend;
    m_tgt  = n_tgt;
    m_id   = n_id;
  endtask

  task automatic idle_cycle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    current_pc = 32'h0;
    pc_valid   = 1'b0;
    jump_ready = 1'b1;
    flush      = 1'b0;
    m_pend     = 1'b0;
    m_tgt      = 32'h0;
    m_id       = 0;
    set_loop(0, 32'h100, 32'h10C, 0);
    set_loop(1, 32'h300, 32'h30C, 0);

    #3;
    check_val("rst_jump", 32'(jump), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_target", target, 32'h0);
    check_val("rst_loop_id", 32'(loop_id), 32'h0);
    check_val("rst_dec", 32'(dec_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic loop, three iterations, fetch always ready.
    set_loop(0, 32'h100, 32'h10C, 3);
    step(32'h10C, 1, 1, 0, 1);
    step(32'h100, 1, 1, 0, 1);
    step(32'h10C, 1, 1, 0, 1);
    step(32'h100, 1, 1, 0, 1);
    step(32'h10C, 1, 1, 0, 1);
    step(32'h110, 1, 1, 0, 1);
    step(32'h10C, 1, 1, 0, 1);
    check_val("basic_cnt0", m_cnt[0], 32'h0);

    // Backpressure, with a retire of the end PC while the request is pending.
    set_loop(0, 32'h100, 32'h10C, 5);
    step(32'h10C, 1, 0, 0, 1);
    step(32'h0, 0, 0, 0, 1);
    step(32'h10C, 1, 0, 0, 1);
    step(32'h0, 0, 0, 0, 1);
    step(32'h0, 0, 1, 0, 1);
    step(32'h0, 0, 1, 0, 1);

    // Flush racing ready in the same request cycle.
    set_loop(0, 32'h100, 32'h10C, 4);
    step(32'h10C, 1, 1, 0, 1);
    step(32'h0, 0, 1, 1, 1);
    step(32'h0, 0, 1, 0, 1);
    // Flush in idle suppresses a hit.
    step(32'h10C, 1, 1, 1, 1);

    // Priority between nested loops sharing one end address.
    set_loop(0, 32'h180, 32'h200, 2);
    set_loop(1, 32'h140, 32'h200, 7);
    step(32'h200, 1, 1, 0, 1);
    step(32'h0, 0, 1, 0, 1);
    step(32'h200, 1, 1, 0, 1);
    step(32'h0, 0, 1, 0, 1);
    check_val("prio_cnt1", m_cnt[1], 32'd7);

    // Inactive counter and non-valid retire.
    set_loop(0, 32'h100, 32'h10C, 0);
    set_loop(1, 32'h300, 32'h30C, 3);
    step(32'h10C, 1, 1, 0, 1);
    step(32'h30C, 0, 1, 0, 1);

    // Asynchronous reset while a request is pending.
    set_loop(0, 32'h100, 32'h10C, 5);
    step(32'h10C, 1, 0, 0, 1);
    @(negedge clk);
    current_pc = 32'h10C;
    pc_valid   = 1'b1;
    jump_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_jump", 32'(jump), 32'h0);
    check_val("arst_busy", 32'(busy), 32'h0);
    check_val("arst_target", target, 32'h0);
    check_val("arst_dec", 32'(dec_cnt), 32'h0);
    m_pend = 1'b0;
    m_tgt  = 32'h0;
    m_id   = 0;
    @(negedge clk);
    pc_valid = 1'b0;
    rst_n    = 1'b1;
    step(32'h0, 0, 1, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      int          r;
      if ($urandom_range(0, 15) == 0) begin
        int k = $urandom_range(0, NR - 1);
        set_loop(k, 32'h1000 + 32'($urandom_range(0, 3)) * 32'h40,
                 32'h2000 + 32'($urandom_range(0, 2)) * 32'h4,
                 32'($urandom_range(0, 4)));
      end
      r = $urandom_range(0, 9);
      if (r < 7) pc = m_end[$urandom_range(0, NR - 1)];
      else       pc = 32'h2000 + 32'($urandom_range(0, 3)) * 32'h4;
      step(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 9) == 0), 1'b0);
    end
    idle_cycle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
